// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the matrix-keypad scanner.
//   - calculator key codes KEY_0..KEY_HASH
//   - scanner FSM state enum
//   - code_w(): output code width (at least 4 bits)
//   - phone_code(): 4x4 calculator layout lookup
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } kp_state_e;

    // Code width for n keys; never narrower than a calculator nibble.
    function automatic int code_w(input int n);
        return ($clog2(n) < 4) ? 4 : $clog2(n);
    endfunction

    // Calculator layout: digits in a phone grid, letters down the right,
    // '*' '0' '#' along the bottom.
    function automatic logic [3:0] phone_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = KEY_0;
        case ({r, c})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            4'hF: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_map.sv
// keypad_map: combinational (row, col) -> key code.
//   i_row   row index of the key
//   i_col   column index of the key
//   o_code  calculator code (PHONE_MAP=1, 4x4 only) or raw row*COLS+col
module keypad_map
    import keypad_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int PHONE_MAP = 1,
    parameter int CODE_W    = 4,
    parameter int RIW       = 2,
    parameter int CIW       = 2
) (
    input  logic [RIW-1:0]    i_row,
    input  logic [CIW-1:0]    i_col,
    output logic [CODE_W-1:0] o_code
);

    generate
        if (PHONE_MAP != 0 && ROWS == 4 && COLS == 4) begin : g_phone
            assign o_code = CODE_W'(phone_code(i_row[1:0], i_col[1:0]));
        end else begin : g_raw
            assign o_code = CODE_W'(i_row) * CODE_W'(COLS) + CODE_W'(i_col);
        end
    endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with debounce and valid/ready output.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   row_n      keypad rows, active-low, asynchronous
//   col_n      column drive, exactly one bit low
//   key_code   code of the accepted key, valid while key_valid
//   key_valid  event pending
//   key_ready  consumer accepts when key_valid && key_ready
//   key_held   a debounced key is down
//   overrun    an event was dropped while the previous one was pending
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int PHONE_MAP       = 1,
    parameter int CODE_W          = code_w(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overrun
);

    localparam int RIW = $clog2(ROWS);
    localparam int CIW = $clog2(COLS);
    localparam int DVW = $clog2(SCAN_DIV);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [ROWS-1:0]   r_sync1, r_sync2;
    kp_state_e         r_state, w_next;
    logic [CIW-1:0]    r_col;
    logic [DVW-1:0]    r_div;
    logic [DBW-1:0]    r_cnt;
    logic [RPW-1:0]    r_rep;
    logic [ROWS-1:0]   r_pat;
    logic [RIW-1:0]    r_row;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_ovr;

    logic [ROWS-1:0]   w_low;
    logic [RIW-1:0]    w_low_idx;
    logic              w_one_low, w_all_high, w_last_dwell, w_match;
    logic              w_deb_done, w_rep_hit;
    logic              w_emit, w_advance, w_latch, w_held;
    logic              w_acc, w_load;
    logic [CODE_W-1:0] w_code;

    // Row synchroniser; idle level is all-ones so reset matches "no key".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_low        = ~r_sync2;
    // Exactly one row low: anything else is idle or a ghosting pattern.
    assign w_one_low    = (w_low != '0) && ((w_low & (w_low - ROWS'(1))) == '0);
    assign w_all_high   = &r_sync2;
    assign w_match      = (r_sync2 == r_pat);
    // Only the last dwell cycle is sampled; earlier ones cover sync latency.
    assign w_last_dwell = (r_div == DVW'(SCAN_DIV - 1));
    assign w_deb_done   = (r_cnt == DBW'(DEBOUNCE_CYCLES - 1));
    assign w_rep_hit    = (REPEAT_CYCLES > 0) && (r_rep == RPW'(REPEAT_CYCLES - 1));

    always_comb begin
        w_low_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (w_low[i]) w_low_idx = RIW'(i);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SCAN;
        else     r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            SCAN:  if (w_last_dwell && w_one_low) w_next = DEB_P;
            DEB_P: if (!w_match)                  w_next = SCAN;
                   else if (w_deb_done)           w_next = HELD;
            HELD:  if (w_all_high)                w_next = DEB_R;
            DEB_R: if (!w_all_high)               w_next = HELD;
                   else if (w_deb_done)           w_next = SCAN;
            default:                              w_next = SCAN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_emit    = 1'b0;
        w_advance = 1'b0;
        w_latch   = 1'b0;
        w_held    = 1'b0;
        case (r_state)
            SCAN: begin
                w_latch   = w_last_dwell && w_one_low;
                w_advance = w_last_dwell && !w_one_low;
            end
            DEB_P: begin
                w_emit    = w_match && w_deb_done;
                w_advance = !w_match;
            end
            HELD: begin
                w_held = 1'b1;
                w_emit = !w_all_high && w_rep_hit;
            end
            DEB_R: begin
                w_held    = 1'b1;
                w_advance = w_all_high && w_deb_done;
            end
            default: ;
        endcase
    end

    assign key_held = w_held;

    // Dwell counter runs only while scanning; restarts on every column change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_div <= '0;
        else if (r_state == SCAN && !w_last_dwell) r_div <= r_div + DVW'(1);
        else                                    r_div <= '0;
    end

    // Column stays frozen from detection until the release is debounced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_col <= '0;
        else if (w_advance)
            r_col <= (r_col == CIW'(COLS - 1)) ? '0 : r_col + CIW'(1);
    end

    assign col_n = ~(COLS'(1) << r_col);

    // Shared debounce counter: stable-pattern cycles in DEB_P, all-ones in DEB_R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (((r_state == DEB_P && w_match) || (r_state == DEB_R && w_all_high)) && !w_deb_done)
            r_cnt <= r_cnt + DBW'(1);
        else
            r_cnt <= '0;
    end

    // Repeat phase counts from HELD entry; a release bounce pauses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rep <= '0;
        else if (REPEAT_CYCLES == 0)
            r_rep <= '0;
        else if (r_state == HELD && !w_all_high)
            r_rep <= w_rep_hit ? '0 : r_rep + RPW'(1);
        else if (r_state == SCAN || r_state == DEB_P)
            r_rep <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat <= '1;
            r_row <= '0;
        end else if (w_latch) begin
            r_pat <= r_sync2;
            r_row <= w_low_idx;
        end
    end

    keypad_map #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .PHONE_MAP (PHONE_MAP),
        .CODE_W    (CODE_W),
        .RIW       (RIW),
        .CIW       (CIW)
    ) u_map (
        .i_row  (r_row),
        .i_col  (r_col),
        .o_code (w_code)
    );

    // Output register: a free slot (empty or being accepted) takes the new
    // event; otherwise the new event is dropped and flagged.
    assign w_acc  = r_valid && key_ready;
    assign w_load = w_emit && (!r_valid || key_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_code  <= w_code;
                r_valid <= 1'b1;
            end else if (w_acc) begin
                r_valid <= 1'b0;
            end
            if (w_emit && !w_load) r_ovr <= 1'b1;
            else if (w_acc)        r_ovr <= 1'b0;
        end
    end

    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Physical keypad: keys[r][c] closed connects row r to column c.
    logic [3:0][3:0] keys;

    logic [3:0] m_row_n, m_col_n, m_code;
    logic       m_valid, m_ready, m_held, m_ovr;
    logic [3:0] p_row_n, p_col_n, p_code;
    logic       p_valid, p_ready, p_held, p_ovr;
    logic [3:0] q_row_n, q_col_n, q_code;
    logic       q_valid, q_held, q_ovr;

    logic man_mode, man_ready, rnd_ready;
    assign m_ready = man_mode ? man_ready : rnd_ready;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int phone_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    function automatic logic [3:0] rows_of(input logic [3:0][3:0] k, input logic [3:0] cn);
        logic [3:0] rn;
        rn = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r][c] && !cn[c]) rn[r] = 1'b0;
        return rn;
    endfunction

    function automatic int ref_code(input int r, input int c, input bit phone);
        if (phone) return phone_tab[r * 4 + c];
        return r * 4 + c;
    endfunction

    assign m_row_n = rows_of(keys, m_col_n);
    assign p_row_n = rows_of(keys, p_col_n);
    assign q_row_n = rows_of(keys, q_col_n);

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
                     .REPEAT_CYCLES(0), .PHONE_MAP(1)) dut (
        .clk(clk), .rst(rst), .row_n(m_row_n), .col_n(m_col_n), .key_code(m_code),
        .key_valid(m_valid), .key_ready(m_ready), .key_held(m_held), .overrun(m_ovr));

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
                     .REPEAT_CYCLES(20), .PHONE_MAP(1)) dut_rep (
        .clk(clk), .rst(rst), .row_n(p_row_n), .col_n(p_col_n), .key_code(p_code),
        .key_valid(p_valid), .key_ready(p_ready), .key_held(p_held), .overrun(p_ovr));

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
                     .REPEAT_CYCLES(20), .PHONE_MAP(0)) dut_raw (
        .clk(clk), .rst(rst), .row_n(q_row_n), .col_n(q_col_n), .key_code(q_code),
        .key_valid(q_valid), .key_ready(1'b1), .key_held(q_held), .overrun(q_ovr));

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2 rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Event monitors: accepted codes (main), load instants (repeat units).
    logic [3:0] got_q[$];
    int         p_t[$];
    logic [3:0] p_c[$];
    int         q_t[$];
    logic [3:0] q_c[$];
    logic       p_pv = 1'b0;
    logic       q_pv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got_q.push_back(m_code);
            if (p_valid && !p_pv) begin p_t.push_back(cyc); p_c.push_back(p_code); end
            if (q_valid && !q_pv) begin q_t.push_back(cyc); q_c.push_back(q_code); end
        end
        p_pv <= p_valid;
        q_pv <= q_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc && n < 0; i++) begin
            @(negedge clk);
            if (m_valid) n = i;
        end
    endtask

    task automatic wait_held(input string tag);
        int k;
        k = 0;
        while (!m_held && k < 40) begin @(negedge clk); k++; end
        chk({tag, "_held_seen"}, m_held, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (m_valid && k < 60) begin @(negedge clk); k++; end
        chk({tag, "_accepted"}, m_valid, 0);
    endtask

    // Clean press/release of one key against the layout model.
    task automatic press_key(input int r, input int c, input string tag);
        int n;
        got_q.delete();
        keys[r][c] = 1'b1;
        wait_valid(27, n);
        chk({tag, "_latency_ok"}, (n >= 1) ? 1 : 0, 1);
        wait_idle(tag);
        #1;
        chk({tag, "_events"}, got_q.size(), 1);
        if (got_q.size() > 0) chk({tag, "_code"}, got_q[0], ref_code(r, c, 1));
        chk({tag, "_held"}, m_held, 1);
        step($urandom_range(0, 20));
        keys[r][c] = 1'b0;
        step(5);
        chk({tag, "_held_in_release_debounce"}, m_held, 1);
        step(9);
        chk({tag, "_released"}, m_held, 0);
        #1;
        chk({tag, "_no_extra"}, got_q.size(), 1);
    endtask

    initial begin
        int n, t0, k;
        logic [3:0] seen;
        logic bad_col;

        rst = 1'b1; keys = '0; man_mode = 1'b0; man_ready = 1'b0; p_ready = 1'b1;
        #1;
        chk("rst_col_n", m_col_n, 4'b1110);
        chk("rst_valid", m_valid, 0);
        chk("rst_overrun", m_ovr, 0);
        chk("rst_held", m_held, 0);
        chk("rst_code", m_code, 0);
        step(3);
        rst = 1'b0;

        // Reset mid-scan.
        step(6);
        #2 rst = 1'b1;
        #1 chk("midscan_rst_col_n", m_col_n, 4'b1110);
        step(1);
        rst = 1'b0;

        press_key(2, 1, "press");

        // Bounce on key A.
        got_q.delete();
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) keys[0][3] = ~keys[0][3];
            step(1);
        end
        #1;
        chk("bounce_no_event", got_q.size(), 0);
        chk("bounce_valid", m_valid, 0);
        chk("bounce_held", m_held, 0);
        press_key(0, 3, "bounce_then_hold");

        // Ghosting: two rows on one column never resolve to a key.
        got_q.delete();
        keys[0][0] = 1'b1; keys[1][0] = 1'b1;
        seen = '0; bad_col = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            k = 0;
            for (int c = 0; c < 4; c++) if (!m_col_n[c]) begin seen[c] = 1'b1; k++; end
            if (k != 1) bad_col = 1'b1;
        end
        #1;
        chk("ghost_no_event", got_q.size(), 0);
        chk("ghost_held", m_held, 0);
        chk("ghost_cols_cycled", seen, 4'hF);
        chk("ghost_one_col_low", bad_col, 0);
        keys = '0;
        step(4);

        // Random presses against the layout model.
        for (int it = 0; it < 6; it++)
            press_key($urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", it));

        // Overrun, reset mid-press, ready pulse.
        man_mode = 1'b1; man_ready = 1'b0;
        keys[1][1] = 1'b1;
        wait_valid(27, n);
        chk("ovr_first_valid", (n >= 1) ? 1 : 0, 1);
        chk("ovr_first_code", m_code, 5);
        keys[1][1] = 1'b0;
        step(14);
        keys[2][2] = 1'b1;
        wait_held("ovr_second");
        step(1);
        chk("ovr_flag", m_ovr, 1);
        chk("ovr_code_kept", m_code, 5);
        chk("ovr_valid_kept", m_valid, 1);

        #2 rst = 1'b1;
        #1;
        chk("held_rst_col_n", m_col_n, 4'b1110);
        chk("held_rst_valid", m_valid, 0);
        chk("held_rst_overrun", m_ovr, 0);
        chk("held_rst_held", m_held, 0);
        chk("held_rst_code", m_code, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(27, n);
        chk("redetect_valid", (n >= 1) ? 1 : 0, 1);
        chk("redetect_code", m_code, 9);
        keys[2][2] = 1'b0;
        step(14);
        keys[0][2] = 1'b1;
        wait_held("ovr_third");
        step(1);
        chk("ovr2_flag", m_ovr, 1);
        chk("ovr2_code_kept", m_code, 9);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        chk("pulse_clears_valid", m_valid, 0);
        chk("pulse_clears_overrun", m_ovr, 0);
        keys[0][2] = 1'b0;
        step(14);
        man_mode = 1'b0;
        wait_idle("pre_repeat");

        // Auto-repeat on '#'; accept and new load in the same cycle.
        p_ready = 1'b0;
        #1;
        p_t.delete(); p_c.delete(); q_t.delete(); q_c.delete(); got_q.delete();
        keys[3][2] = 1'b1;
        k = 0;
        while (!p_valid && k < 40) begin @(negedge clk); k++; end
        chk("rep_first_seen", p_valid, 1);
        t0 = cyc;
        step(19);
        p_ready = 1'b1;
        step(1);
        chk("rep_accept_and_load_valid", p_valid, 1);
        chk("rep_accept_and_load_ovr", p_ovr, 0);
        chk("rep_accept_and_load_code", p_code, 15);
        step(30);
        keys[3][2] = 1'b0;
        step(14);
        wait_idle("rep_main");
        #1;
        chk("rep_rises", p_t.size(), 2);
        if (p_t.size() == 2) begin
            chk("rep_first_time", p_t[0], t0);
            chk("rep_third_gap", p_t[1] - p_t[0], 40);
            chk("rep_third_code", p_c[1], 15);
        end
        chk("raw_events", q_t.size(), 3);
        if (q_t.size() == 3) begin
            chk("raw_gap1", q_t[1] - q_t[0], 20);
            chk("raw_gap2", q_t[2] - q_t[1], 20);
            chk("raw_code0", q_c[0], ref_code(3, 2, 0));
            chk("raw_code2", q_c[2], ref_code(3, 2, 0));
        end
        chk("norep_events", got_q.size(), 1);
        if (got_q.size() > 0) chk("norep_code", got_q[0], ref_code(3, 2, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
